// File: rtl/mips_step_controller.sv
// Run/step controller for the mips_32 core: gates core_en for a burst, single step or free run,
// stopping early on halt request or PC breakpoint and reporting stop cause and cycle counts.
module mips_step_controller #(
  parameter int CNT_WIDTH  = 16,
  parameter int ADDR_WIDTH = 32,
  parameter int NUM_BP     = 2,
  parameter int BPI_WIDTH  = 1
) (
  input  logic                         clock,
  input  logic                         reset_n,
  input  logic [1:0]                   mode,
  input  logic                         start,
  input  logic                         halt_req,
  input  logic [CNT_WIDTH-1:0]         burst_len,
  input  logic [ADDR_WIDTH-1:0]        pc,
  input  logic [NUM_BP*ADDR_WIDTH-1:0] bp_addr,
  input  logic [NUM_BP-1:0]            bp_en,
  output logic                         core_en,
  output logic                         busy,
  output logic                         done,
  output logic [1:0]                   stop_cause,
  output logic [BPI_WIDTH-1:0]         bp_index,
  output logic [CNT_WIDTH-1:0]         cycle_count,
  output logic [31:0]                  total_cycles
);

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    DONE = 2'b10
  } state_t;

  localparam logic [1:0] MODE_BURST = 2'b00;
  localparam logic [1:0] MODE_FREE  = 2'b10;
  localparam logic [1:0] MODE_RSVD  = 2'b11;

  state_t                 state_reg, state_next;
  logic                   free_reg, free_next;
  logic [CNT_WIDTH-1:0]   remaining_reg, remaining_next;
  logic [CNT_WIDTH-1:0]   cycle_count_reg, cycle_count_next;
  logic [31:0]            total_reg, total_next;
  logic [1:0]             stop_cause_reg, stop_cause_next;
  logic [BPI_WIDTH-1:0]   bp_index_reg, bp_index_next;

  logic [NUM_BP-1:0]      bp_hit;
  logic [BPI_WIDTH-1:0]   bp_first;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_BP; gi++) begin : g_bp
      assign bp_hit[gi] = bp_en[gi] && (pc == bp_addr[gi*ADDR_WIDTH +: ADDR_WIDTH]);
    end
  endgenerate

  // Scan from the top down so the lowest matching index wins.
  always_comb begin
    bp_first = '0;
    for (int i = NUM_BP - 1; i >= 0; i--) begin
      if (bp_hit[i]) bp_first = BPI_WIDTH'(i);
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_reg       <= IDLE;
      free_reg        <= 1'b0;
      remaining_reg   <= '0;
      cycle_count_reg <= '0;
      total_reg       <= '0;
      stop_cause_reg  <= 2'b00;
      bp_index_reg    <= '0;
    end else begin
      state_reg       <= state_next;
      free_reg        <= free_next;
      remaining_reg   <= remaining_next;
      cycle_count_reg <= cycle_count_next;
      total_reg       <= total_next;
      stop_cause_reg  <= stop_cause_next;
      bp_index_reg    <= bp_index_next;
    end
  end

  always_comb begin
    state_next       = state_reg;
    free_next        = free_reg;
    remaining_next   = remaining_reg;
    cycle_count_next = cycle_count_reg;
    total_next       = total_reg;
    stop_cause_next  = stop_cause_reg;
    bp_index_next    = bp_index_reg;
    case (state_reg)
      IDLE: begin
        if (start && mode != MODE_RSVD) begin
          cycle_count_next = '0;
          stop_cause_next  = 2'b00;
          bp_index_next    = '0;
          free_next        = (mode == MODE_FREE);
          remaining_next   = (mode == MODE_BURST) ? burst_len : CNT_WIDTH'(1);
          if (mode == MODE_BURST && burst_len == '0) state_next = DONE;
          else                                       state_next = RUN;
        end
      end
      RUN: begin
        cycle_count_next = cycle_count_reg + 1'b1;
        if (total_reg != 32'hFFFF_FFFF) total_next = total_reg + 32'd1;
        if (!free_reg) remaining_next = remaining_reg - 1'b1;
        if (halt_req) begin
          stop_cause_next = 2'b01;
          state_next      = DONE;
        end else if (|bp_hit) begin
          stop_cause_next = 2'b10;
          bp_index_next   = bp_first;
          state_next      = DONE;
        end else if (!free_reg && remaining_reg == CNT_WIDTH'(1)) begin
          stop_cause_next = 2'b00;
          state_next      = DONE;
        end
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  assign core_en      = (state_reg == RUN);
  assign busy         = (state_reg != IDLE);
  assign done         = (state_reg == DONE);
  assign stop_cause   = stop_cause_reg;
  assign bp_index     = bp_index_reg;
  assign cycle_count  = cycle_count_reg;
  assign total_cycles = total_reg;

endmodule

// File: tb/tb_mips_step_controller.sv
// Bench for mips_step_controller: transaction-level reference model checked every cycle,
// plus directed scenarios with hand-computed expectations.
module tb_mips_step_controller;

  logic        clock = 1'b0;
  logic        reset_n;
  logic [1:0]  mode;
  logic        start;
  logic        halt_req;
  logic [15:0] burst_len;
  logic [31:0] pc;
  logic [63:0] bp_addr;
  logic [1:0]  bp_en;
  logic        core_en, busy, done;
  logic [1:0]  stop_cause;
  logic [0:0]  bp_index;
  logic [15:0] cycle_count;
  logic [31:0] total_cycles;

  int vectors = 0;
  int miscompares = 0;
  bit pc_follow = 1'b0;

  mips_step_controller #(.CNT_WIDTH(16), .ADDR_WIDTH(32), .NUM_BP(2), .BPI_WIDTH(1)) dut (
    .clock(clock), .reset_n(reset_n), .mode(mode), .start(start), .halt_req(halt_req),
    .burst_len(burst_len), .pc(pc), .bp_addr(bp_addr), .bp_en(bp_en),
    .core_en(core_en), .busy(busy), .done(done), .stop_cause(stop_cause),
    .bp_index(bp_index), .cycle_count(cycle_count), .total_cycles(total_cycles)
  );

  always #5 clock = ~clock;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a run is "active" while cycles remain, and a finished run leaves one done cycle.
  bit     m_active = 0, m_finishing = 0, m_free = 0;
  int     m_left = 0, m_cc = 0, m_cause = 0, m_idx = 0;
  longint m_total = 0;

  always @(posedge clock or negedge reset_n) begin
    int hit;
    if (!reset_n) begin
      m_active = 0; m_finishing = 0; m_free = 0;
      m_left = 0; m_cc = 0; m_cause = 0; m_idx = 0; m_total = 0;
    end else if (m_finishing) begin
      m_finishing = 0;
    end else if (m_active) begin
      m_cc = (m_cc + 1) % 65536;
      if (m_total < 64'hFFFF_FFFF) m_total++;
      hit = -1;
      for (int i = 0; i < 2; i++)
        if (hit < 0 && bp_en[i] && pc == bp_addr[i*32 +: 32]) hit = i;
      if (halt_req)                      begin m_cause = 1; m_active = 0; m_finishing = 1; end
      else if (hit >= 0)                 begin m_cause = 2; m_idx = hit; m_active = 0; m_finishing = 1; end
      else if (!m_free && m_left == 1)   begin m_cause = 0; m_active = 0; m_finishing = 1; end
      else if (!m_free)                  m_left--;
    end else if (start && mode != 2'b11) begin
      m_cc = 0; m_cause = 0; m_idx = 0;
      m_free = (mode == 2'b10);
      m_left = (mode == 2'b00) ? int'(burst_len) : 1;
      if (mode == 2'b00 && burst_len == 0) m_finishing = 1;
      else                                 m_active = 1;
    end
  end

  always @(negedge clock) begin
    chk("core_en",      core_en,      m_active);
    chk("busy",         busy,         m_active || m_finishing);
    chk("done",         done,         m_finishing);
    chk("stop_cause",   stop_cause,   m_cause);
    chk("bp_index",     bp_index,     m_idx);
    chk("cycle_count",  cycle_count,  m_cc);
    chk("total_cycles", total_cycles, m_total[31:0]);
  end

  task automatic tick();
    logic ce;
    ce = core_en;
    @(posedge clock);
    #2;
    if (pc_follow && ce) pc = pc + 32'd4;
  endtask

  task automatic launch(input logic [1:0] m, input logic [15:0] len);
    mode = m; burst_len = len; start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic observe(input int n, output int ce_cnt, output int done_cyc);
    ce_cnt = 0; done_cyc = -1;
    for (int k = 1; k <= n; k++) begin
      if (core_en) ce_cnt++;
      if (done && done_cyc < 0) done_cyc = k;
      tick();
    end
  endtask

  int ce_cnt, done_cyc;

  initial begin
    reset_n = 1'b0; mode = 2'b00; start = 1'b0; halt_req = 1'b0; burst_len = '0;
    pc = '0; bp_addr = {32'h18, 32'h10}; bp_en = 2'b00;
    #1;
    chk("rst core_en", core_en, 1'b0);
    chk("rst busy", busy, 1'b0);
    chk("rst done", done, 1'b0);
    chk("rst total", total_cycles, 32'd0);
    tick(); tick();
    reset_n = 1'b1;
    tick();

    // burst of 7
    launch(2'b00, 16'd7);
    observe(10, ce_cnt, done_cyc);
    chk("burst ce cycles", ce_cnt, 7);
    chk("burst done cycle", done_cyc, 8);
    chk("burst cycle_count", cycle_count, 16'd7);
    chk("burst total", total_cycles, 32'd7);
    $display("burst: ce=%0d done@%0d cc=%0d", ce_cnt, done_cyc, cycle_count);

    // three single steps
    for (int s = 0; s < 3; s++) begin
      launch(2'b01, 16'd50);
      observe(4, ce_cnt, done_cyc);
      chk("step ce cycles", ce_cnt, 1);
      chk("step done cycle", done_cyc, 2);
      $display("step %0d: ce=%0d done@%0d", s, ce_cnt, done_cyc);
    end
    chk("step total", total_cycles, 32'd10);

    // free run halted in the 20th RUN cycle
    launch(2'b10, 16'd0);
    repeat (19) tick();
    halt_req = 1'b1;
    tick();
    halt_req = 1'b0;
    chk("halt done", done, 1'b1);
    chk("halt core_en", core_en, 1'b0);
    chk("halt cycle_count", cycle_count, 16'd20);
    chk("halt cause", stop_cause, 2'b01);
    $display("free+halt: cc=%0d cause=%0d", cycle_count, stop_cause);
    tick(); tick();

    // breakpoint at 0x10, pc advancing by 4 per core_en
    pc = 32'h0; pc_follow = 1'b1; bp_en = 2'b11;
    launch(2'b00, 16'd100);
    observe(10, ce_cnt, done_cyc);
    chk("bp ce cycles", ce_cnt, 5);
    chk("bp cycle_count", cycle_count, 16'd5);
    chk("bp cause", stop_cause, 2'b10);
    chk("bp index", bp_index, 1'b0);
    $display("breakpoint: ce=%0d cc=%0d cause=%0d idx=%0d", ce_cnt, cycle_count, stop_cause, bp_index);
    pc_follow = 1'b0; bp_en = 2'b00;

    // burst_len 0 goes straight to done
    launch(2'b00, 16'd0);
    chk("len0 done", done, 1'b1);
    chk("len0 core_en", core_en, 1'b0);
    chk("len0 cause", stop_cause, 2'b00);
    chk("len0 cycle_count", cycle_count, 16'd0);
    tick(); tick();
    $display("burst_len 0: done pulse, no core_en");

    // reserved mode is ignored
    launch(2'b11, 16'd5);
    chk("rsvd busy", busy, 1'b0);
    tick();
    chk("rsvd busy2", busy, 1'b0);
    $display("mode 11: busy=%0b", busy);

    // start during RUN is ignored
    launch(2'b00, 16'd5);
    tick();
    mode = 2'b01; burst_len = 16'd2; start = 1'b1;
    tick();
    start = 1'b0;
    observe(8, ce_cnt, done_cyc);
    chk("ign cycle_count", cycle_count, 16'd5);
    chk("ign total", total_cycles, 32'd40);
    $display("start in RUN: cc=%0d total=%0d", cycle_count, total_cycles);

    // reset in cycle 3 of a burst of 10
    launch(2'b00, 16'd10);
    tick(); tick();
    reset_n = 1'b0;
    #1;
    chk("rst mid core_en", core_en, 1'b0);
    chk("rst mid busy", busy, 1'b0);
    chk("rst mid cycle_count", cycle_count, 16'd0);
    chk("rst mid total", total_cycles, 32'd0);
    tick();
    reset_n = 1'b1;
    tick();
    launch(2'b00, 16'd10);
    observe(14, ce_cnt, done_cyc);
    chk("post rst ce cycles", ce_cnt, 10);
    chk("post rst done cycle", done_cyc, 11);
    chk("post rst total", total_cycles, 32'd10);
    $display("reset mid-run: rerun ce=%0d done@%0d", ce_cnt, done_cyc);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
